// File: rtl/jk_excite_seq.sv
// jk_excite_seq: drives J/K of an external JK flop so that its Q follows a target sequence, checking Q each step
// Ports:
//   clk        rising-edge clock (the driven flop samples J/K on the falling edge)
//   rst        asynchronous active-low reset
//   pat_valid  pattern offer; accepted when pat_ready is high
//   pat_ready  high only in IDLE
//   pat_data   target Q sequence, bit 0 first
//   pat_len_m1 sequence length minus one
//   q_fb       Q fed back from the driven flop
//   J, K       registered excitation outputs
//   busy       high while the sequence is being driven
//   done       one-cycle completion pulse
//   err        sticky mismatch flag for the current/last sequence
//   err_idx    step index of the first mismatch
// Build option: define JK_TOGGLE_EN for hold/toggle excitation; otherwise set/reset excitation.
module jk_excite_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        pat_valid,
  output logic        pat_ready,
  input  logic [15:0] pat_data,
  input  logic [3:0]  pat_len_m1,
  input  logic        q_fb,
  output logic        J,
  output logic        K,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [3:0]  err_idx
);
  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;
  state_t      state, state_n;
  logic [15:0] pat, pat_n;
  logic [3:0]  len, len_n, idx, idx_n, err_idx_n;
  logic        j_n, k_n, err_n;
  function automatic logic [1:0] excite(input logic p, input logic n);
`ifdef JK_TOGGLE_EN
    return {n ^ p, n ^ p};
`else
    return {n, ~n};
`endif
  endfunction
  assign pat_ready = state == IDLE;
  assign busy      = state == DRIVE;
  assign done      = state == DONE;
  // Steps after the first use the expected previous target as present state,
  // so a faulty flop cannot steer the excitation away from the pattern.
  always_comb begin
    state_n   = state;
    pat_n     = pat;
    len_n     = len;
    idx_n     = idx;
    err_n     = err;
    err_idx_n = err_idx;
    {j_n, k_n} = 2'b00;
    case (state)
      IDLE: if (pat_valid) begin
        state_n    = DRIVE;
        pat_n      = pat_data;
        len_n      = pat_len_m1;
        idx_n      = 4'd0;
        err_n      = 1'b0;
        err_idx_n  = 4'd0;
        {j_n, k_n} = excite(q_fb, pat_data[0]);
      end
      DRIVE: begin
        if (q_fb != pat[idx] && !err) begin
          err_n     = 1'b1;
          err_idx_n = idx;
        end
        if (idx == len) state_n = DONE;
        else begin
          idx_n      = idx + 4'd1;
          {j_n, k_n} = excite(pat[idx], pat[idx_n]);
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      pat     <= 16'd0;
      len     <= 4'd0;
      idx     <= 4'd0;
      J       <= 1'b0;
      K       <= 1'b0;
      err     <= 1'b0;
      err_idx <= 4'd0;
    end else begin
      state   <= state_n;
      pat     <= pat_n;
      len     <= len_n;
      idx     <= idx_n;
      J       <= j_n;
      K       <= k_n;
      err     <= err_n;
      err_idx <= err_idx_n;
    end
  end
endmodule

// File: tb/tb_jk_excite_seq.sv
// tb_jk_excite_seq: scoreboard bench driving jk_excite_seq against an ideal JK flop model
module tb_jk_excite_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pat_valid = 1'b0;
  logic        pat_ready;
  logic [15:0] pat_data = 16'd0;
  logic [3:0]  pat_len_m1 = 4'd0;
  logic        q_fb;
  logic        J, K, busy, done, err;
  logic [3:0]  err_idx;
  logic        q = 1'b0;
  logic        force_q = 1'b0;
  int          tests = 0, fails = 0;
  int          edges, step, ff;
  logic        hold_en = 1'b0;
  logic [15:0] hold_d = 16'd0;
  logic [3:0]  hold_l = 4'd0;
  typedef struct packed {logic e; logic [3:0] i; logic [3:0] l;} res_t;
  logic [1:0]  jk_q[$];
  res_t        res_q[$];
  jk_excite_seq dut (
    .clk(clk), .rst(rst), .pat_valid(pat_valid), .pat_ready(pat_ready),
    .pat_data(pat_data), .pat_len_m1(pat_len_m1), .q_fb(q_fb),
    .J(J), .K(K), .busy(busy), .done(done), .err(err), .err_idx(err_idx)
  );
  always #5 clk = ~clk;
  always @(negedge clk)
    case ({J, K})
      2'b10: q <= 1'b1;
      2'b01: q <= 1'b0;
      2'b11: q <= ~q;
      default: ;
    endcase
  assign q_fb = force_q ? 1'b0 : q;
  function automatic logic [1:0] ex(input logic p, input logic n);
`ifdef JK_TOGGLE_EN
    return {p ^ n, p ^ n};
`else
    return {n, ~n};
`endif
  endfunction
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic pop_jk();
    logic [1:0] e;
    if (jk_q.size() == 0) chk("jk_queue_empty", 16'd1, 16'd0);
    else begin
      e = jk_q.pop_front();
      chk($sformatf("jk_step%0d", step), {14'd0, J, K}, {14'd0, e});
    end
  endtask
  task automatic step_one();
    @(posedge clk); #1;
    edges++;
    if (busy) begin
      step++;
      pop_jk();
      if (ff >= 0 && step >= ff) force_q = 1'b1;
    end
  endtask
  task automatic start(input logic [15:0] d, input logic [3:0] l, input int f, input logic ee, input logic [3:0] ei);
    logic p;
    int t = 0;
    while (!pat_ready && t < 10) begin
      @(posedge clk); #1;
      t++;
    end
    chk("ready_before_accept", {15'd0, pat_ready}, 16'd1);
    p = q_fb;
    for (int i = 0; i <= int'(l); i++) begin
      jk_q.push_back(ex(p, d[i]));
      p = d[i];
    end
    res_q.push_back('{e: ee, i: ei, l: l});
    pat_valid = 1'b1;
    pat_data = d;
    pat_len_m1 = l;
    ff = f;
    step = 0;
    @(posedge clk); #1;
    edges = 1;
    if (hold_en) begin
      pat_data = hold_d;
      pat_len_m1 = hold_l;
    end else pat_valid = 1'b0;
    chk("err_clear_at_accept", {15'd0, err}, 16'd0);
    chk("busy_after_accept", {15'd0, busy}, 16'd1);
    pop_jk();
    if (ff == 0) force_q = 1'b1;
  endtask
  task automatic finish();
    res_t r;
    while (!done && edges < 40) step_one();
    chk("done_seen", {15'd0, done}, 16'd1);
    if (res_q.size() == 0) chk("res_queue_empty", 16'd1, 16'd0);
    else begin
      r = res_q.pop_front();
      chk("latency", 16'(edges), 16'(int'(r.l) + 2));
      chk("err", {15'd0, err}, {15'd0, r.e});
      chk("err_idx", {12'd0, err_idx}, {12'd0, r.i});
    end
    chk("jk_in_done", {14'd0, J, K}, 16'd0);
    chk("busy_in_done", {15'd0, busy}, 16'd0);
    force_q = 1'b0;
  endtask
  initial begin
    #2 rst = 1'b0;
    #1;
    chk("rst_ready", {15'd0, pat_ready}, 16'd1);
    chk("rst_jk", {14'd0, J, K}, 16'd0);
    chk("rst_busy_done_err", {13'd0, busy, done, err}, 16'd0);
    chk("rst_err_idx", {12'd0, err_idx}, 16'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    start(16'h0005, 4'd3, -1, 1'b0, 4'd0);
    finish();
    @(posedge clk); #1;
    chk("done_one_cycle", {15'd0, done}, 16'd0);
    chk("q_after_0005", {15'd0, q}, 16'd0);
    start(16'h000F, 4'd3, 2, 1'b1, 4'd2);
    finish();
    start(16'h0001, 4'd0, -1, 1'b0, 4'd0);
    finish();
    hold_en = 1'b1;
    hold_d = 16'hFFFF;
    hold_l = 4'd1;
    start(16'h0006, 4'd3, 0, 1'b1, 4'd1);
    finish();
    hold_en = 1'b0;
    @(posedge clk); #1;
    chk("idle_after_done", {15'd0, pat_ready}, 16'd1);
    chk("err_held_in_idle", {15'd0, err}, 16'd1);
    start(16'hFFFF, 4'd1, -1, 1'b0, 4'd0);
    finish();
    start(16'hA5A5, 4'd15, -1, 1'b0, 4'd0);
    repeat (4) step_one();
    #2 rst = 1'b0;
    #1;
    chk("abort_jk", {14'd0, J, K}, 16'd0);
    chk("abort_busy", {15'd0, busy}, 16'd0);
    chk("abort_ready", {15'd0, pat_ready}, 16'd1);
    chk("abort_done", {15'd0, done}, 16'd0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("no_done_in_rst", {15'd0, done}, 16'd0);
    end
    rst = 1'b1;
    jk_q.delete();
    res_q.delete();
    force_q = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("no_done_after_abort", {15'd0, done}, 16'd0);
    end
    start(16'hA5A5, 4'd15, -1, 1'b0, 4'd0);
    finish();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/jk_excite_seq.md
JK_EXCITE_SEQ -- requirements
Module: jk_excite_seq

Interface
REQ-001 SHALL have ports (clock and reset first):
- clk  input  1  rising-edge system clock; the driven JK flop samples J/K on the falling edge of the same clk
- rst  input  1  reset, asynchronous, active-low
- pat_valid  input  1  pattern offer
- pat_ready  output  1  block can accept a pattern
- pat_data  input  16  target Q sequence, bit 0 first
- pat_len_m1  input  4  sequence length minus 1 (1..16 steps)
- q_fb  input  1  Q fed back from the driven JK flop
- J  output  1  registered J drive
- K  output  1  registered K drive
- busy  output  1  sequence in progress
- done  output  1  one-cycle completion pulse
- err  output  1  sticky mismatch flag for the current/last sequence
- err_idx  output  4  step index of the first mismatch
REQ-002 SHALL contain no parameters; all widths fixed as listed.

Function
REQ-003 SHALL implement FSM states IDLE, DRIVE, DONE; pat_ready=1 only in IDLE; busy=1 only in DRIVE.
REQ-004 Accept edge = rising clk with pat_valid=1 and pat_ready=1; the block SHALL latch pat_data and pat_len_m1, set idx=0, take present state p=q_fb, clear err and err_idx, load J/K for step 0, and enter DRIVE.
REQ-005 pat_valid outside IDLE SHALL be ignored; latched pattern unchanged.
REQ-006 Excitation for present p and target n SHALL follow the Configuration section; J/K change only on rising clk.
REQ-007 Each rising edge in DRIVE SHALL compare q_fb with pat[idx]; on mismatch with err=0, SHALL set err=1 and err_idx=idx; later mismatches SHALL not change err_idx.
REQ-008 On that edge, if idx==pat_len_m1: SHALL drive J=0,K=0 and enter DONE; else SHALL set idx=idx+1 and load J/K for target pat[idx+1] with present state pat[idx] (expected state, not q_fb).
REQ-009 DONE SHALL last exactly one cycle with done=1, then return to IDLE; err/err_idx SHALL hold until the next accept or reset.
REQ-010 Latency: accept edge to done-high cycle SHALL be pat_len_m1+2 rising edges; back-to-back accept possible in the cycle after DONE.
REQ-011 In IDLE and DONE, J=0 and K=0 (driven flop holds).
REQ-012 pat_len_m1=0 SHALL run one step; pat_len_m1=15 SHALL use all 16 bits; idx SHALL never wrap.

Reset
REQ-013 rst low SHALL immediately force IDLE, J=0, K=0, done=0, err=0, err_idx=0, idx=0, busy=0, pat_ready=1, regardless of clk.
REQ-014 Reset asserted mid-DRIVE SHALL abort the sequence with no done pulse; first accept after release SHALL start a fresh sequence.
REQ-015 Reset release SHALL take effect on the first rising clk after rst goes high.

Configuration
REQ-016 Macro JK_TOGGLE_EN SHALL select the excitation encoding.
REQ-017 With JK_TOGGLE_EN defined: n==p -> J=0,K=0 (hold); n!=p -> J=1,K=1 (toggle).
REQ-018 Without JK_TOGGLE_EN: J=n, K=~n (set/reset only, independent of p).
REQ-019 Sequencing, check, and timing SHALL be identical in both builds.

Verification
REQ-020 Reset mid-sequence: pat_data=16'hA5A5, pat_len_m1=15, rst low after 5 steps -> J=K=0, busy=0, pat_ready=1 immediately, no done pulse.
REQ-021 Ideal JK flop model on falling clk, q_fb=0 at accept, pat_data=16'h0005, pat_len_m1=3 -> Q sequence 1,0,1,0; done 5 edges after accept; err=0.
REQ-022 Same stimulus, JK_TOGGLE_EN defined -> J/K steps 11,11,11,11; undefined -> 10,01,10,01.
REQ-023 q_fb forced to 0 from step 2 of pat_data=16'h000F, pat_len_m1=3 -> err=1, err_idx=2, unchanged after step 3 mismatch.
REQ-024 pat_valid held high during DRIVE with new pat_data=16'hFFFF -> ignored; second accept occurs in the IDLE cycle after DONE; err cleared at that accept.
REQ-025 pat_len_m1=0, pat_data bit0=1, q_fb=1 -> toggle build J=K=0, set/reset build J=1,K=0; done 2 edges after accept.
